seq_pattern_tx: RTL and testbench

//  Serial pattern transmitter: drives the single-bit stream consumed by the lab0 sequence-detector fsm (its In).

---
 rtl/seq_pattern_tx_if.sv | 37 +++
 rtl/seq_pattern_tx.sv | 88 ++++++++
 tb/tb_seq_pattern_tx.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/seq_pattern_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_pattern_tx_if
//  Purpose  : Groups the load handshake and the serial output of
//             seq_pattern_tx.
//  Ports    : none (interface). Parameters WIDTH/CNT_W must match the
//             transmitter they connect to.
//             master : load_valid, load_data, load_reps, abort driven;
//                      load_ready, out_bit, out_valid, busy, done observed.
//             slave  : the transmitter side (mirror of master).
//  Revision : 1.0  initial release
// ============================================================================
interface seq_pattern_tx_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic [CNT_W-1:0] load_reps;
    logic             abort;
    logic             out_bit;
    logic             out_valid;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, load_data, load_reps, abort,
        input  load_ready, out_bit, out_valid, busy, done
    );

    modport slave (
        input  load_valid, load_data, load_reps, abort,
        output load_ready, out_bit, out_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module   : seq_pattern_tx
//  Purpose  : Serial pattern transmitter. Accepts a WIDTH-bit pattern and a
//             repeat count, then shifts the pattern out MSB-first, one bit
//             per clock, (reps+1) times back-to-back, followed by a one-cycle
//             done pulse.
//  Ports    : clock  - rising-edge clock
//             reset  - asynchronous active-low reset
//             bus    - seq_pattern_tx_if.slave (load handshake, abort,
//                      out_bit/out_valid serial stream, busy, done)
//  Revision : 1.0  initial release
// ============================================================================
module seq_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  wire logic       clock,
    input  wire logic       reset,
    seq_pattern_tx_if.slave bus
);
    localparam int BCW = $clog2(WIDTH);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hold;     // copy of the pattern for reloading each pass
    logic [BCW-1:0]   bit_cnt;  // bits remaining in the current pass, minus one
    logic [CNT_W-1:0] rep_cnt;  // passes remaining after the current one

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            shreg   <= '0;
            hold    <= '0;
            bit_cnt <= '0;
            rep_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // abort is deliberately not looked at here
                    if (bus.load_valid) begin
                        shreg   <= bus.load_data;
                        hold    <= bus.load_data;
                        rep_cnt <= bus.load_reps;
                        bit_cnt <= LAST_BIT;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.abort) begin
                        state <= IDLE;
                    end else if (bit_cnt != '0) begin
                        shreg   <= {shreg[WIDTH-2:0], 1'b0};
                        bit_cnt <= bit_cnt - 1'b1;
                    end else if (rep_cnt != '0) begin
                        // next pass starts on the very next cycle, no gap
                        shreg   <= hold;
                        bit_cnt <= LAST_BIT;
                        rep_cnt <= rep_cnt - 1'b1;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs depend only on registered state and shreg.
    assign bus.load_ready = (state == IDLE);
    assign bus.out_valid  = (state == SHIFT);
    assign bus.out_bit    = (state == SHIFT) && shreg[WIDTH-1];
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == DONE);
endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_pattern_tx
//  Purpose  : Self-checking bench for seq_pattern_tx: a table of directed
//             single-cycle vectors plus hand-written multi-cycle sequences
//             (repeats, async reset, load held during transmission, max reps).
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_pattern_tx;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic clock;
    logic reset;

    seq_pattern_tx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    seq_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // expected outputs packed as {load_ready, out_valid, out_bit, busy, done}
    localparam logic [4:0] E_S1 = 5'b01110;
    localparam logic [4:0] E_S0 = 5'b01010;
    localparam logic [4:0] E_DN = 5'b00011;
    localparam logic [4:0] E_ID = 5'b10000;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic [3:0] reps;
        logic       abort;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl [0:18];

    function automatic vec_t mk(logic vl, logic [7:0] d, logic [3:0] r,
                                logic ab, logic [4:0] e);
        vec_t t;
        t.valid = vl;
        t.data  = d;
        t.reps  = r;
        t.abort = ab;
        t.exp   = e;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] outs();
        return {bus.load_ready, bus.out_valid, bus.out_bit, bus.busy, bus.done};
    endfunction

    // advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic vl, input logic [7:0] d,
                         input logic [3:0] r, input logic ab);
        bus.load_valid = vl;
        bus.load_data  = d;
        bus.load_reps  = r;
        bus.abort      = ab;
    endtask

    // Called in the first SHIFT cycle; checks every bit of every pass, the
    // done cycle, and the following IDLE cycle (returns in that IDLE cycle).
    task automatic expect_stream(input string name, input logic [7:0] d,
                                 input int reps);
        for (int p = 0; p <= reps; p++) begin
            for (int i = 0; i < WIDTH; i++) begin
                chk({name, " valid"}, 32'(bus.out_valid), 32'd1);
                chk({name, " bit"},   32'(bus.out_bit),   32'(d[WIDTH-1-i]));
                chk({name, " nodone"},32'(bus.done),      32'd0);
                step();
            end
        end
        chk({name, " done"}, 32'(outs()), 32'(E_DN));
        step();
        chk({name, " idle"}, 32'(outs()), 32'(E_ID));
    endtask

    initial begin
        // test 1: B2, reps 0
        tbl[0]  = mk(1'b1, 8'hB2, 4'd0, 1'b0, E_S1);
        tbl[1]  = mk(1'b0, 8'h00, 4'd0, 1'b0, E_S0);
        tbl[2]  = mk(1'b0, 8'h00, 4'd0, 1'b0, E_S1);
        tbl[3]  = mk(1'b0, 8'h00, 4'd0, 1'b0, E_S1);
        tbl[4]  = mk(1'b0, 8'h00, 4'd0, 1'b0, E_S0);
        tbl[5]  = mk(1'b0, 8'h00, 4'd0, 1'b0, E_S0);
        tbl[6]  = mk(1'b0, 8'h00, 4'd0, 1'b0, E_S1);
        tbl[7]  = mk(1'b0, 8'h00, 4'd0, 1'b0, E_S0);
        tbl[8]  = mk(1'b0, 8'h00, 4'd0, 1'b0, E_DN);
        tbl[9]  = mk(1'b0, 8'h00, 4'd0, 1'b0, E_ID);
        // test 3: abort sampled at the end of the 4th SHIFT cycle
        tbl[10] = mk(1'b1, 8'hB2, 4'd0, 1'b0, E_S1);
        tbl[11] = mk(1'b0, 8'h00, 4'd0, 1'b0, E_S0);
        tbl[12] = mk(1'b0, 8'h00, 4'd0, 1'b0, E_S1);
        tbl[13] = mk(1'b0, 8'h00, 4'd0, 1'b0, E_S1);
        tbl[14] = mk(1'b0, 8'h00, 4'd0, 1'b1, E_ID);
        // abort ignored in IDLE, load together with abort still accepted
        tbl[15] = mk(1'b0, 8'h00, 4'd0, 1'b1, E_ID);
        tbl[16] = mk(1'b1, 8'h40, 4'd0, 1'b1, E_S0);
        tbl[17] = mk(1'b0, 8'h00, 4'd0, 1'b0, E_S1);
        tbl[18] = mk(1'b0, 8'h00, 4'd0, 1'b1, E_ID);

        // reset state, with a load request that must be ignored
        reset = 1'b0;
        drive(1'b1, 8'hFF, 4'd3, 1'b0);
        #1;
        chk("reset outs", 32'(outs()), 32'(E_ID));
        step();
        step();
        chk("reset held outs", 32'(outs()), 32'(E_ID));
        drive(1'b0, 8'h00, 4'd0, 1'b0);
        reset = 1'b1;
        step();
        chk("post reset idle", 32'(outs()), 32'(E_ID));

        for (int k = 0; k < 19; k++) begin
            drive(tbl[k].valid, tbl[k].data, tbl[k].reps, tbl[k].abort);
            step();
            chk($sformatf("vec%0d", k), 32'(outs()), 32'(tbl[k].exp));
        end
        drive(1'b0, 8'h00, 4'd0, 1'b0);
        step();
        chk("after table idle", 32'(outs()), 32'(E_ID));

        // test 2: reps=2, three back-to-back passes, single done
        drive(1'b1, 8'hB2, 4'd2, 1'b0);
        step();
        drive(1'b0, 8'h00, 4'd0, 1'b0);
        expect_stream("rep2", 8'hB2, 2);

        // test 4: asynchronous reset during bit 5 of A5
        drive(1'b1, 8'hA5, 4'd0, 1'b0);
        step();
        drive(1'b0, 8'h00, 4'd0, 1'b0);
        for (int i = 0; i < 4; i++) step();
        chk("A5 bit5 before reset", 32'(outs()), 32'(E_S0));
        #2;
        reset = 1'b0;
        #1;
        chk("async reset outs", 32'(outs()), 32'(E_ID));
        step();
        chk("reset held idle", 32'(outs()), 32'(E_ID));
        reset = 1'b1;
        drive(1'b1, 8'h3C, 4'd0, 1'b0);
        step();
        drive(1'b0, 8'h00, 4'd0, 1'b0);
        expect_stream("3C", 8'h3C, 0);

        // test 5: load_valid held high with FF during a transmission of 00
        drive(1'b1, 8'h00, 4'd0, 1'b0);
        step();
        drive(1'b1, 8'hFF, 4'd0, 1'b0);
        expect_stream("00 held", 8'h00, 0);
        step();
        drive(1'b0, 8'h00, 4'd0, 1'b0);
        expect_stream("FF", 8'hFF, 0);

        // test 6: max repeats, 16 passes of 81 = 128 bits, done at k+129
        drive(1'b1, 8'h81, 4'hF, 1'b0);
        step();
        drive(1'b0, 8'h00, 4'd0, 1'b0);
        expect_stream("81x16", 8'h81, 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
